layer_mixer: RTL

- Parametrised pixel compositor between the VGA timing generator (display) and the physical RGB pins; successor to the fixed text-overlay top.
- Combines NUM_LAYERS overlay sources (text, HUD, sprites, ...) by fixed priority over a background colour.
- Adds per-layer enable, per-layer frame-based blinking, tear-free config shadowing and a pipeline that keeps sync aligned with colour.

---
 rtl/layer_mixer.sv | 101 ++++++++++
 1 files changed

// File: rtl/layer_mixer.sv
// rtl/layer_mixer.sv - priority compositor of overlay layers over a background, with blink and sync-aligned pipeline
module layer_mixer #(
  parameter int NUM_LAYERS   = 4,
  parameter int COLOR_W      = 4,
  parameter int PIPE_STAGES  = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            p_tick,
  input  logic                            video_on,
  input  logic                            hsync_in,
  input  logic                            vsync_in,
  input  logic [NUM_LAYERS-1:0]           layer_on,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
  input  logic [3*COLOR_W-1:0]            bg_rgb,
  input  logic [NUM_LAYERS-1:0]           cfg_enable,
  input  logic [NUM_LAYERS-1:0]           cfg_blink,
  output logic [COLOR_W-1:0]              red,
  output logic [COLOR_W-1:0]              green,
  output logic [COLOR_W-1:0]              blue,
  output logic                            hsync,
  output logic                            vsync,
  output logic                            frame_start
);

  localparam int RGB_W = 3 * COLOR_W;
  localparam int CNT_W = $clog2(BLINK_FRAMES) + 1;
  localparam int SW    = RGB_W + 2;

  logic                  vsync_prev;
  logic                  frame_bnd;
  logic                  cnt_wrap;
  logic [CNT_W-1:0]      frame_cnt;
  logic                  blink_phase;
  logic [NUM_LAYERS-1:0] en_sh;
  logic [NUM_LAYERS-1:0] blink_sh;
  logic [NUM_LAYERS-1:0] en_eff;
  logic [NUM_LAYERS-1:0] blink_eff;
  logic                  phase_eff;
  logic [NUM_LAYERS-1:0] eligible;
  logic [RGB_W-1:0]      sel_rgb;
  logic [SW-1:0]         pipe [PIPE_STAGES];

  // Frame boundary is a vsync falling edge seen on a pixel tick.
  assign frame_bnd = p_tick & ~vsync_in & vsync_prev;
  assign cnt_wrap  = (frame_cnt == CNT_W'(BLINK_FRAMES - 1));

  // On the boundary pixel itself, selection already sees the config and phase about to be loaded.
  assign en_eff    = frame_bnd ? cfg_enable : en_sh;
  assign blink_eff = frame_bnd ? cfg_blink : blink_sh;
  assign phase_eff = (frame_bnd & cnt_wrap) ? ~blink_phase : blink_phase;
  assign eligible  = layer_on & en_eff & (~blink_eff | {NUM_LAYERS{phase_eff}});

  // Frame tracking: edge detector, shadow config load and blink counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_prev  <= 1'b1;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
      en_sh       <= '1;
      blink_sh    <= '0;
    end else begin
      frame_start <= frame_bnd;
      if (p_tick) vsync_prev <= vsync_in;
      if (frame_bnd) begin
        en_sh    <= cfg_enable;
        blink_sh <= cfg_blink;
        if (cnt_wrap) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Lowest-index eligible layer wins; background otherwise; black outside the visible area.
  always_comb begin
    sel_rgb = bg_rgb;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eligible[i]) sel_rgb = layer_rgb[i*RGB_W +: RGB_W];
    end
    if (!video_on) sel_rgb = '0;
  end

  // Colour and sync share one register chain so they stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < PIPE_STAGES; s++) pipe[s] <= {{RGB_W{1'b0}}, 2'b11};
    end else if (p_tick) begin
      pipe[0] <= {sel_rgb, hsync_in, vsync_in};
      for (int s = 1; s < PIPE_STAGES; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign {red, green, blue, hsync, vsync} = pipe[PIPE_STAGES-1];

endmodule
